// File: rtl/run_controller.sv
// rtl/run_controller.sv - run sequencer: program entry table, core launch, retire/cycle counters, watchdog
module run_controller #(
  parameter int num_progs      = 4,
  parameter int addr_width     = 9,
  parameter int cnt_width      = 16,
  parameter int timeout_cycles = 4096,
  parameter int sel_width      = (num_progs > 1) ? $clog2(num_progs) : 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [sel_width-1:0]  prog_sel_i,
  input  logic                  base_we_i,
  input  logic [sel_width-1:0]  base_idx_i,
  input  logic [addr_width-1:0] base_din_i,
  input  logic                  core_done_i,
  input  logic                  core_stall_i,
  output logic                  core_start_o,
  output logic [addr_width-1:0] start_addr_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  timeout_o,
  output logic [cnt_width-1:0]  instr_count_o,
  output logic [cnt_width-1:0]  cycle_count_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [cnt_width-1:0] CNT_ONE = cnt_width'(1);
  localparam int unsigned LIMIT = (timeout_cycles > 0) ? timeout_cycles - 1 : 0;

  state_t                state_q;
  logic                  core_start_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  timeout_q;
  logic [addr_width-1:0] start_addr_q;
  logic [cnt_width-1:0]  instr_count_q;
  logic [cnt_width-1:0]  cycle_count_q;
  logic [addr_width-1:0] table_q [num_progs];

  logic [sel_width-1:0]  sel_d;
  logic [cnt_width-1:0]  instr_count_d;
  logic [cnt_width-1:0]  cycle_count_d;
  logic                  limit_hit;
  logic                  start_ok;

  always_comb begin
    sel_d         = (32'(prog_sel_i) < num_progs) ? prog_sel_i : '0;
    cycle_count_d = (&cycle_count_q) ? cycle_count_q : cycle_count_q + CNT_ONE;
    instr_count_d = (core_stall_i || (&instr_count_q)) ? instr_count_q
                                                       : instr_count_q + CNT_ONE;
    limit_hit     = (timeout_cycles != 0) && (32'(cycle_count_q) == LIMIT);
    start_ok      = start_i && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                                (state_q == S_FAULT));
  end

  // Table reads use the pre-write value, so a same-cycle write+launch sees the old entry.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      core_start_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      start_addr_q  <= '0;
      instr_count_q <= '0;
      cycle_count_q <= '0;
      for (int i = 0; i < num_progs; i++) begin
        table_q[i] <= '0;
      end
    end else begin
      if (base_we_i && (32'(base_idx_i) < num_progs)) begin
        table_q[base_idx_i] <= base_din_i;
      end
      case (state_q)
        S_IDLE, S_DONE, S_FAULT: begin
          if (start_ok) begin
            state_q       <= S_LOAD;
            start_addr_q  <= table_q[sel_d];
            instr_count_q <= '0;
            cycle_count_q <= '0;
            core_start_q  <= 1'b1;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
          end
        end
        S_LOAD: begin
          state_q      <= S_RUN;
          core_start_q <= 1'b0;
        end
        S_RUN: begin
          if (core_done_i) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cycle_count_q <= cycle_count_d;
            instr_count_q <= instr_count_d;
            if (limit_hit) begin
              state_q   <= S_FAULT;
              busy_q    <= 1'b0;
              timeout_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q      <= S_IDLE;
          core_start_q <= 1'b0;
          busy_q       <= 1'b0;
          done_q       <= 1'b0;
          timeout_q    <= 1'b0;
        end
      endcase
    end
  end

  assign core_start_o  = core_start_q;
  assign start_addr_o  = start_addr_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign timeout_o     = timeout_q;
  assign instr_count_o = instr_count_q;
  assign cycle_count_o = cycle_count_q;

endmodule
